spi_master: RTL and testbench

- Byte-wide SPI mode-0 master, MSB first; single shared SCK/MOSI/MISO bus.
- Sits directly downstream of the UART bootloader: consumes its spi_data_tx / spi_txn_start / spi_force_clock and returns spi_data_rx / spi_txn_done.
- Chip selects are driven by the bootloader, not by this block.
- Also supplies free-running dummy clocks (MOSI high) on request.

---
 rtl/spi_master.sv | 157 +++++++++++++++
 tb/tb_spi_master.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// spi_master : byte-wide SPI mode-0 master (MSB first) with dummy clocking
// Revision   : 1.0
// ============================================================================
module spi_master #(
  parameter int HALF_PERIOD = 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] spi_data_tx,
  input  logic       spi_txn_start,
  input  logic       spi_force_clock,
  output logic [7:0] spi_data_rx,
  output logic       spi_txn_done,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FORCE = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_HALF_M1 = CNT_WIDTH'(HALF_PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

  state_t               r_state, w_state;
  logic                 r_pending, w_pending;
  logic [7:0]           r_tx_hold, w_tx_hold;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt;
  logic [3:0]           r_edge_cnt, w_edge_cnt;
  logic [7:0]           r_shift, w_shift;
  logic                 r_sck, w_sck;
  logic                 r_mosi, w_mosi;
  logic [7:0]           r_data_rx, w_data_rx;
  logic                 r_txn_done, w_txn_done;
  logic                 w_edge;
  logic                 w_capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pending  <= 1'b0;
      r_tx_hold  <= 8'h00;
      r_cnt      <= '0;
      r_edge_cnt <= 4'd0;
      r_shift    <= 8'h00;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b1;
      r_data_rx  <= 8'h00;
      r_txn_done <= 1'b1;
    end else begin
      r_state    <= w_state;
      r_pending  <= w_pending;
      r_tx_hold  <= w_tx_hold;
      r_cnt      <= w_cnt;
      r_edge_cnt <= w_edge_cnt;
      r_shift    <= w_shift;
      r_sck      <= w_sck;
      r_mosi     <= w_mosi;
      r_data_rx  <= w_data_rx;
      r_txn_done <= w_txn_done;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_pending  = r_pending;
    w_tx_hold  = r_tx_hold;
    w_cnt      = r_cnt;
    w_edge_cnt = r_edge_cnt;
    w_shift    = r_shift;
    w_sck      = r_sck;
    w_mosi     = r_mosi;
    w_data_rx  = r_data_rx;
    w_txn_done = r_txn_done;
    w_edge     = (r_cnt == c_HALF_M1);

    // A start coinciding with IDLE->BUSY launch belongs to the launching transfer
    w_capture = spi_txn_start && (r_state != ST_BUSY) &&
                !((r_state == ST_IDLE) && r_pending);
    if (w_capture) begin
      w_pending  = 1'b1;
      w_tx_hold  = spi_data_tx;
      w_txn_done = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        w_cnt = '0;
        w_sck = 1'b0;
        if (r_pending) begin
          w_state    = ST_BUSY;
          w_shift    = r_tx_hold;
          w_mosi     = r_tx_hold[7];
          w_edge_cnt = 4'd0;
          w_pending  = 1'b0;
        end else if (spi_force_clock) begin
          w_state = ST_FORCE;
          w_mosi  = 1'b1;
        end else begin
          w_mosi = 1'b1;
        end
      end

      ST_FORCE: begin
        w_mosi = 1'b1;
        if (w_edge) begin
          w_cnt = '0;
          w_sck = ~r_sck;
          // Only leave on a falling edge so SCK always ends low
          if (r_sck && (!spi_force_clock || w_pending)) begin
            w_state = ST_IDLE;
          end
        end else begin
          w_cnt = r_cnt + c_CNT_ONE;
        end
      end

      ST_BUSY: begin
        if (w_edge) begin
          w_cnt      = '0;
          w_sck      = ~r_sck;
          w_edge_cnt = r_edge_cnt + 4'd1;
          if (!r_sck) begin
            w_shift = {r_shift[6:0], spi_miso};
          end else if (r_edge_cnt == 4'd15) begin
            w_data_rx  = r_shift;
            w_mosi     = 1'b1;
            w_txn_done = !w_pending;
            w_state    = ST_IDLE;
          end else begin
            w_mosi = r_shift[7];
          end
        end else begin
          w_cnt = r_cnt + c_CNT_ONE;
        end
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  assign spi_data_rx  = r_data_rx;
  assign spi_txn_done = r_txn_done;
  assign spi_sck      = r_sck;
  assign spi_mosi     = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_spi_master : directed scoreboard bench for spi_master
// Revision      : 1.0
// ============================================================================
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] spi_data_tx = 8'h00;
  logic       spi_txn_start = 1'b0;
  logic       spi_force_clock = 1'b0;
  logic [7:0] spi_data_rx;
  logic       spi_txn_done;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;
  logic       loopback = 1'b1;
  logic       miso_fixed = 1'b0;

  assign spi_miso = loopback ? spi_mosi : miso_fixed;

  spi_master #(.HALF_PERIOD(2), .CNT_WIDTH(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .spi_data_tx    (spi_data_tx),
    .spi_txn_start  (spi_txn_start),
    .spi_force_clock(spi_force_clock),
    .spi_data_rx    (spi_data_rx),
    .spi_txn_done   (spi_txn_done),
    .spi_sck        (spi_sck),
    .spi_mosi       (spi_mosi),
    .spi_miso       (spi_miso)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  logic [7:0] exp_rx_q[$];
  logic       exp_bit_q[$];
  int cyc = 0, last_rise = 0, rise_period = 0;
  int busy_rises = 0, done_rises = 0, done_low = 0, sck_edges = 0;
  int cur_high = 0, last_high = 0;
  logic prev_sck = 1'b0, prev_done = 1'b1, mosi_low_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (got === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
  endtask

  // Monitor samples 3ns after each rising clock edge
  always @(posedge clk) begin
    #3;
    cyc = cyc + 1;
    if (!rst_n) begin
      cur_high = 0;
    end else begin
      if (spi_sck != prev_sck) sck_edges = sck_edges + 1;
      if (spi_sck && !prev_sck) begin
        rise_period = cyc - last_rise;
        last_rise   = cyc;
        if (!spi_txn_done) begin
          busy_rises = busy_rises + 1;
          if (exp_bit_q.size() == 0) check("sck_rise_expected", 32'(exp_bit_q.size() != 0), 1);
          else check("mosi_bit", spi_mosi, exp_bit_q.pop_front());
        end
      end
      if (spi_sck) cur_high = cur_high + 1;
      else if (cur_high != 0) begin
        last_high = cur_high;
        cur_high  = 0;
      end
      if (!spi_txn_done) done_low = done_low + 1;
      if (spi_txn_done && !prev_done) begin
        done_rises = done_rises + 1;
        if (exp_rx_q.size() == 0) check("rx_expected", 32'(exp_rx_q.size() != 0), 1);
        else check("rx_byte", spi_data_rx, exp_rx_q.pop_front());
      end
      if (spi_force_clock && spi_txn_done && !spi_mosi) mosi_low_seen = 1'b1;
    end
    prev_sck  = spi_sck;
    prev_done = spi_txn_done;
  end

  task automatic send_start(input logic [7:0] tx, input logic [7:0] exp);
    @(negedge clk);
    spi_data_tx   = tx;
    spi_txn_start = 1'b1;
    exp_rx_q.push_back(exp);
    for (int i = 7; i >= 0; i--) exp_bit_q.push_back(tx[i]);
    @(negedge clk);
    spi_txn_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    for (int i = 0; i < max_cyc && !spi_txn_done; i++) @(negedge clk);
    check("done_wait", spi_txn_done, 1);
  endtask

  task automatic xfer(input logic [7:0] tx, input logic [7:0] exp);
    send_start(tx, exp);
    wait_done(200);
  endtask

  int e0;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_sck", spi_sck, 0);
    check("rst_mosi", spi_mosi, 1);
    check("rst_rx", spi_data_rx, 8'h00);
    check("rst_done", spi_txn_done, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback A5
    done_low = 0;
    xfer(8'hA5, 8'hA5);
    check("a5_done_low", done_low, 33);
    check("a5_sck_idle", spi_sck, 0);
    check("a5_rx", spi_data_rx, 8'hA5);

    // Fixed MISO levels
    loopback   = 1'b0;
    miso_fixed = 1'b0;
    xfer(8'h3C, 8'h00);
    check("miso0_rx", spi_data_rx, 8'h00);
    miso_fixed = 1'b1;
    xfer(8'h00, 8'hFF);
    repeat (10) @(negedge clk);
    check("rx_hold", spi_data_rx, 8'hFF);
    loopback = 1'b1;

    // Start pulse during a transfer is ignored
    busy_rises = 0;
    done_rises = 0;
    send_start(8'hC3, 8'hC3);
    repeat (8) @(negedge clk);
    spi_data_tx   = 8'h11;
    spi_txn_start = 1'b1;
    @(negedge clk);
    spi_txn_start = 1'b0;
    wait_done(200);
    repeat (40) @(negedge clk);
    check("c3_rises", busy_rises, 8);
    check("c3_done_rises", done_rises, 1);
    check("c3_rx", spi_data_rx, 8'hC3);

    // Free-running dummy clocks
    mosi_low_seen   = 1'b0;
    spi_force_clock = 1'b1;
    repeat (20) @(negedge clk);
    check("force_period", rise_period, 4);
    check("force_high_len", last_high, 2);
    check("force_mosi_high", mosi_low_seen, 0);
    for (int i = 0; i < 10 && !spi_sck; i++) @(negedge clk);
    check("force_sck_high", spi_sck, 1);
    e0 = sck_edges;
    spi_force_clock = 1'b0;
    repeat (12) @(negedge clk);
    check("force_end_sck", spi_sck, 0);
    check("force_end_edges", sck_edges - e0, 1);
    check("force_last_high", last_high, 2);
    check("force_rx_kept", spi_data_rx, 8'hC3);

    // Start during force clocking with SCK high
    spi_force_clock = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10 && !spi_sck; i++) @(negedge clk);
    check("fs_sck_high", spi_sck, 1);
    busy_rises = 0;
    spi_data_tx   = 8'h96;
    spi_txn_start = 1'b1;
    exp_rx_q.push_back(8'h96);
    for (int i = 7; i >= 0; i--) exp_bit_q.push_back(spi_data_tx[i]);
    @(negedge clk);
    spi_txn_start = 1'b0;
    check("fs_done_drop", spi_txn_done, 0);
    wait_done(200);
    spi_force_clock = 1'b0;
    repeat (12) @(negedge clk);
    check("fs_rises", busy_rises, 8);
    check("fs_rx", spi_data_rx, 8'h96);
    check("fs_sck_idle", spi_sck, 0);

    // Reset at the 7th SCK edge of a transfer
    e0 = sck_edges;
    send_start(8'hF0, 8'hF0);
    for (int i = 0; i < 100 && (sck_edges - e0) < 7; i++) @(negedge clk);
    check("abort_edge", sck_edges - e0, 7);
    rst_n = 1'b0;
    #1;
    check("abort_sck", spi_sck, 0);
    check("abort_mosi", spi_mosi, 1);
    check("abort_done", spi_txn_done, 1);
    check("abort_rx", spi_data_rx, 8'h00);
    exp_rx_q.delete();
    exp_bit_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    xfer(8'h5A, 8'h5A);
    check("post_rst_rx", spi_data_rx, 8'h5A);
    repeat (4) @(negedge clk);
    check("rx_queue_empty", exp_rx_q.size(), 0);
    check("bit_queue_empty", exp_bit_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
